// File: rtl/fifo_mon_pkg.sv
// Shared definitions for the FIFO protocol monitor: error-bit positions and the
// per-channel error vector type.
package fifo_mon_pkg;
  localparam int ERR_OVF  = 0;
  localparam int ERR_UDF  = 1;
  localparam int ERR_FLAG = 2;
  localparam int ERR_PTR  = 3;
  localparam int NUM_ERR  = 4;

  typedef logic [NUM_ERR-1:0] fifo_err_t;
endpackage

// File: rtl/fifo_mon_ch.sv
// One monitored channel: shadow pointers and occupancy built from accepted
// handshakes, plus combinational detection of the four error classes.
module fifo_mon_ch
  import fifo_mon_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic               ren,
  input  logic               full,
  input  logic               empty,
  input  logic [ADDR_SIZE:0] wr_ptr,
  input  logic [ADDR_SIZE:0] rd_ptr,
  output logic [ADDR_SIZE:0] occ,
  output fifo_err_t          err
);

  localparam logic [ADDR_SIZE:0] DEPTH_V = (ADDR_SIZE+1)'(DEPTH);

  logic [ADDR_SIZE:0] exp_wptr;
  logic [ADDR_SIZE:0] exp_rptr;
  logic               wr_acc;
  logic               rd_acc;

  assign wr_acc = wen && !full;
  assign rd_acc = ren && !empty;

  always_comb begin
    err           = '0;
    err[ERR_OVF]  = wen && full;
    err[ERR_UDF]  = ren && empty;
    err[ERR_FLAG] = (empty != (occ == '0)) || (full != (occ == DEPTH_V));
    err[ERR_PTR]  = (wr_ptr != exp_wptr) || (rd_ptr != exp_rptr);
  end

  // Pointers are one bit wider than the address, so natural overflow gives
  // the mod 2*DEPTH wrap. The shadow is never resynchronised to the DUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_wptr <= '0;
      exp_rptr <= '0;
      occ      <= '0;
    end else begin
      if (wr_acc) exp_wptr <= exp_wptr + 1'b1;
      if (rd_acc) exp_rptr <= exp_rptr + 1'b1;
      if (wr_acc && !rd_acc)
        occ <= occ + 1'b1;
      else if (rd_acc && !wr_acc)
        occ <= occ - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_monitor_mc.sv
// Multi-channel FIFO protocol monitor: per-channel shadow checkers feeding sticky
// status, a saturating error-cycle counter and first-error capture.
module fifo_monitor_mc
  import fifo_mon_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 16,
  parameter int ADDR_SIZE = 4,
  parameter int ERR_CNT_W = 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic [NUM_CH-1:0]               wen,
  input  logic [NUM_CH-1:0]               ren,
  input  logic [NUM_CH-1:0]               full,
  input  logic [NUM_CH-1:0]               empty,
  input  logic [NUM_CH*(ADDR_SIZE+1)-1:0] wr_ptr,
  input  logic [NUM_CH*(ADDR_SIZE+1)-1:0] rd_ptr,
  output logic [NUM_CH*(ADDR_SIZE+1)-1:0] occ,
  output logic [NUM_CH*NUM_ERR-1:0]       err_sticky,
  output logic                            err_any,
  output logic [ERR_CNT_W-1:0]            err_cnt,
  output logic                            first_err_valid,
  output logic [CH_W-1:0]                 first_err_ch,
  output fifo_err_t                       first_err_type
);

  localparam int PW = ADDR_SIZE + 1;

  fifo_err_t                  ch_err [NUM_CH];
  logic [NUM_CH*NUM_ERR-1:0]  err_flat;
  logic                       new_err;
  logic [CH_W-1:0]            pick_ch;
  fifo_err_t                  pick_vec;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_mon_ch #(
      .DEPTH     (DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .wen    (wen[c]),
      .ren    (ren[c]),
      .full   (full[c]),
      .empty  (empty[c]),
      .wr_ptr (wr_ptr[c*PW +: PW]),
      .rd_ptr (rd_ptr[c*PW +: PW]),
      .occ    (occ[c*PW +: PW]),
      .err    (ch_err[c])
    );
    assign err_flat[c*NUM_ERR +: NUM_ERR] = ch_err[c];
  end

  assign new_err = |err_flat;
  assign err_any = |err_sticky;

  // Scan downward so the lowest-index erroring channel is the one left selected.
  always_comb begin
    pick_ch  = '0;
    pick_vec = '0;
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (|ch_err[c]) begin
        pick_ch  = CH_W'(c);
        pick_vec = ch_err[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky      <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
      first_err_type  <= '0;
    end else if (clr) begin
      err_sticky      <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
      first_err_type  <= '0;
    end else begin
      err_sticky <= err_sticky | err_flat;
      if (new_err && (err_cnt != {ERR_CNT_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
      if (!first_err_valid && new_err) begin
        first_err_valid <= 1'b1;
        first_err_ch    <= pick_ch;
        first_err_type  <= pick_vec;
      end
    end
  end

endmodule

// File: tb/tb_fifo_monitor_mc.sv
// Bench for fifo_monitor_mc: directed scenarios plus a randomized phase, all
// checked against a queue-free arithmetic model of the monitor's rules.
module tb_fifo_monitor_mc;
  localparam int NUM_CH    = 2;
  localparam int DEPTH     = 16;
  localparam int ADDR_SIZE = 4;
  localparam int ERR_CNT_W = 8;
  localparam int PTR_MOD   = 2 * DEPTH;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [1:0]  wen, ren, full, empty;
  logic [4:0]  wp [2];
  logic [4:0]  rp [2];
  logic [9:0]  wr_ptr, rd_ptr, occ;
  logic [7:0]  err_sticky;
  logic        err_any;
  logic [7:0]  err_cnt;
  logic        first_err_valid;
  logic [0:0]  first_err_ch;
  logic [3:0]  first_err_type;

  assign wr_ptr = {wp[1], wp[0]};
  assign rd_ptr = {rp[1], rp[0]};

  always #5 clk = ~clk;

  fifo_monitor_mc #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_SIZE(ADDR_SIZE), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .ren(ren), .full(full), .empty(empty),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .occ(occ), .err_sticky(err_sticky),
    .err_any(err_any), .err_cnt(err_cnt), .first_err_valid(first_err_valid),
    .first_err_ch(first_err_ch), .first_err_type(first_err_type)
  );

  int         m_occ [2];
  int         m_wp  [2];
  int         m_rp  [2];
  logic [3:0] m_sticky [2];
  int         m_cnt;
  logic       m_fv;
  int         m_fch;
  logic [3:0] m_ftype;
  int         checks = 0;
  int         errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] modelErr(input int c);
    logic [3:0] e;
    e[0] = wen[c] && full[c];
    e[1] = ren[c] && empty[c];
    e[2] = (empty[c] != (m_occ[c] == 0)) || (full[c] != (m_occ[c] == DEPTH));
    e[3] = (int'(wp[c]) != m_wp[c]) || (int'(rp[c]) != m_rp[c]);
    return e;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      m_occ[c] = 0; m_wp[c] = 0; m_rp[c] = 0; m_sticky[c] = '0;
    end
    m_cnt = 0; m_fv = 1'b0; m_fch = 0; m_ftype = '0;
  endtask

  // Applies one clock edge's worth of rules, using the inputs held across the edge.
  task automatic modelClock();
    logic [3:0] e [2];
    logic       any_e;
    int         wa, ra;
    any_e = 1'b0;
    for (int c = 0; c < 2; c++) begin
      e[c] = modelErr(c);
      any_e |= |e[c];
    end
    if (clr) begin
      m_sticky[0] = '0; m_sticky[1] = '0;
      m_cnt = 0; m_fv = 1'b0; m_fch = 0; m_ftype = '0;
    end else begin
      for (int c = 0; c < 2; c++) m_sticky[c] |= e[c];
      if (any_e && m_cnt < CNT_MAX) m_cnt++;
      if (!m_fv && any_e) begin
        m_fv    = 1'b1;
        m_fch   = (e[0] != 4'b0000) ? 0 : 1;
        m_ftype = e[m_fch];
      end
    end
    for (int c = 0; c < 2; c++) begin
      wa = (wen[c] && !full[c]) ? 1 : 0;
      ra = (ren[c] && !empty[c]) ? 1 : 0;
      m_wp[c]  = (m_wp[c] + wa) % PTR_MOD;
      m_rp[c]  = (m_rp[c] + ra) % PTR_MOD;
      m_occ[c] = (m_occ[c] + wa - ra) & (PTR_MOD - 1);
    end
  endtask

  task automatic checkOutput();
    checkVal("occ0", {22'b0, occ[4:0]}, m_occ[0]);
    checkVal("occ1", {22'b0, occ[9:5]}, m_occ[1]);
    checkVal("err_sticky", {24'b0, err_sticky}, {24'b0, m_sticky[1], m_sticky[0]});
    checkVal("err_any", {31'b0, err_any}, {31'b0, |{m_sticky[1], m_sticky[0]}});
    checkVal("err_cnt", {24'b0, err_cnt}, m_cnt);
    checkVal("first_err_valid", {31'b0, first_err_valid}, {31'b0, m_fv});
    checkVal("first_err_ch", {31'b0, first_err_ch}, m_fch);
    checkVal("first_err_type", {28'b0, first_err_type}, {28'b0, m_ftype});
  endtask

  // A well-behaved FIFO: flags and pointers consistent with the model's view.
  task automatic consistent();
    for (int c = 0; c < 2; c++) begin
      full[c]  = (m_occ[c] == DEPTH);
      empty[c] = (m_occ[c] == 0);
      wp[c]    = 5'(m_wp[c]);
      rp[c]    = 5'(m_rp[c]);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] w, input logic [1:0] r);
    clr = 1'b0;
    wen = w;
    ren = r;
    consistent();
  endtask

  task automatic tick();
    @(posedge clk);
    modelClock();
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    applyStimulus(2'b00, 2'b00);
    rst = 1'b0;
  endtask

  initial begin
    int base_w, base_r;
    rst = 1'b1; clr = 1'b0; wen = '0; ren = '0; full = '0; empty = '1;
    wp[0] = '0; wp[1] = '0; rp[0] = '0; rp[1] = '0;
    doReset();

    // Fill ch0 with 16 clean writes.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(2'b01, 2'b00);
      tick();
      checkVal("fill_no_err", {31'b0, err_any}, 0);
    end
    checkVal("fill_occ0", {27'b0, occ[4:0]}, 16);

    // Underflow attempt on ch1.
    applyStimulus(2'b00, 2'b10);
    tick();
    checkVal("udf_sticky_ch1", {28'b0, err_sticky[7:4]}, 4'b0010);
    checkVal("udf_cnt", {24'b0, err_cnt}, 1);
    checkVal("udf_first_ch", {31'b0, first_err_ch}, 1);
    checkVal("udf_first_type", {28'b0, first_err_type}, 4'b0010);

    applyStimulus(2'b00, 2'b00);
    clr = 1'b1;
    tick();
    checkVal("clr_valid", {31'b0, first_err_valid}, 0);

    // Drain ch0 to 5, then three simultaneous write/read cycles.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(2'b00, 2'b01);
      tick();
    end
    checkVal("drain_occ0", {27'b0, occ[4:0]}, 5);
    base_w = 16; base_r = 11;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b01, 2'b01);
      wp[0] = 5'(base_w + k);
      rp[0] = 5'(base_r + k);
      tick();
    end
    applyStimulus(2'b00, 2'b00);
    wp[0] = 5'(base_w + 3);
    rp[0] = 5'(base_r + 3);
    tick();
    checkVal("rw_occ0", {27'b0, occ[4:0]}, 5);
    checkVal("rw_ptr_plus3", {31'b0, err_any}, 0);

    // 40 pairs cross the 31->0 pointer wrap.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(2'b01, 2'b01);
      tick();
    end
    checkVal("wrap_no_ptr", {31'b0, err_sticky[3]}, 0);
    applyStimulus(2'b00, 2'b00);
    wp[0] = wp[0] + 5'd1;
    tick();
    checkVal("ptr_off_by_one", {31'b0, err_sticky[3]}, 1);

    // Flag lie on ch0 at occ=3 with a simultaneous overflow on ch1.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 2'b00);
      tick();
    end
    applyStimulus(2'b10, 2'b00);
    empty[0] = 1'b1;
    full[1]  = 1'b1;
    tick();
    checkVal("flag_first_ch", {31'b0, first_err_ch}, 0);
    checkVal("flag_first_type", {28'b0, first_err_type}, 4'b0100);
    checkVal("ovf_sticky_ch1", {28'b0, err_sticky[7:4]}, 4'b0101);

    // Counter saturation, clear with an error present, then reset mid-burst.
    doReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(2'b00, 2'b10);
      tick();
    end
    checkVal("cnt_saturated", {24'b0, err_cnt}, 255);
    applyStimulus(2'b00, 2'b10);
    clr = 1'b1;
    tick();
    checkVal("clr_cnt", {24'b0, err_cnt}, 0);
    checkVal("clr_sticky", {24'b0, err_sticky}, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b00, 2'b10);
      tick();
    end
    #2;
    doReset();

    // Randomized traffic with occasional flag/pointer faults and clears.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(2'($urandom), 2'($urandom));
      if ($urandom_range(15) == 0) full[$urandom_range(1)] ^= 1'b1;
      if ($urandom_range(15) == 0) empty[$urandom_range(1)] ^= 1'b1;
      if ($urandom_range(39) == 0) rp[$urandom_range(1)] ^= 5'd4;
      if ($urandom_range(29) == 0) clr = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog observed=timeout expected=completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_monitor_mc.md
# fifo_monitor_mc

Synthesizable, multi-channel run-time protocol monitor for the bridge's synchronous FIFOs. It shadows each channel's occupancy and read/write pointers from the observed handshakes, then flags four error classes per channel:

- overflow attempt
- underflow attempt
- full/empty flag mismatch
- pointer mismatch

Errors are latched into sticky status with a saturating error counter and first-error capture, so failures are visible in silicon and in regression without simulator-only checks.

## Interface
Parameters:
- NUM_CH, 2, number of monitored FIFO channels
- DEPTH, 16, entries per FIFO (power of two)
- ADDR_SIZE, 4, log2(DEPTH); pointers and occupancy are ADDR_SIZE+1 bits
- ERR_CNT_W, 8, width of the saturating error counter

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  monitor clock, same clock as the monitored FIFOs
- rst  in  1  asynchronous active-high reset
- clr  in  1  synchronous clear of status (sticky, counter, first-error); shadow state untouched
- wen  in  NUM_CH  per-channel write request
- ren  in  NUM_CH  per-channel read request
- full  in  NUM_CH  per-channel DUT full flag
- empty  in  NUM_CH  per-channel DUT empty flag
- wr_ptr  in  NUM_CH*(ADDR_SIZE+1)  DUT write pointers, channel c at [c*(ADDR_SIZE+1) +: ADDR_SIZE+1]
- rd_ptr  in  NUM_CH*(ADDR_SIZE+1)  DUT read pointers, same packing
- occ  out  NUM_CH*(ADDR_SIZE+1)  shadow occupancy per channel, same packing
- err_sticky  out  NUM_CH*4  sticky error bits, channel c at [c*4 +: 4]
- err_any  out  1  OR of all err_sticky bits
- err_cnt  out  ERR_CNT_W  count of cycles with at least one new error, saturating
- first_err_valid  out  1  first-error record is held
- first_err_ch  out  $clog2(NUM_CH) (min 1)  channel of the first error
- first_err_type  out  4  that channel's error vector in the capture cycle

## Operation
Per-channel shadow state, updated on every clk:
- The channel holds exp_wptr, exp_rptr and occ.
- A write is accepted when wen && !full. On acceptance, exp_wptr advances by 1 mod 2*DEPTH.
- A read is accepted when ren && !empty. On acceptance, exp_rptr advances by 1 mod 2*DEPTH.
- occ changes as follows:
  - +1 on an accepted write only.
  - −1 on an accepted read only.
  - Unchanged when both are accepted in the same cycle, or when neither is.
- Refused (rejected) requests never change shadow state.

Error bits are combinational detections for cycle t, all evaluated against shadow state at the start of cycle t:
- bit0 OVF: wen && full.
- bit1 UDF: ren && empty.
- bit2 FLAG: (empty != (occ==0)) || (full != (occ==DEPTH)).
- bit3 PTR: (wr_ptr != exp_wptr) || (rd_ptr != exp_rptr).

Status, updated on every clk:
- err_sticky ORs in the detected bits.
- err_cnt increments by 1 in any cycle where any channel detects any bit. It saturates at 2^ERR_CNT_W−1.
- If first_err_valid is 0 and an error is detected, the block captures the lowest-index erroring channel and that channel's 4-bit vector, then sets first_err_valid.
- clr has priority: err_sticky, err_cnt and first_err are zeroed, and errors detected in the clr cycle are dropped.

## Timing
- Reset values: occ, exp_wptr, exp_rptr, err_sticky, err_cnt, first_err_* and err_any are all 0.
- Shadow latency is 1 cycle: a handshake at edge t is reflected in occ after edge t.
- Error latency is 1 cycle: an error detected in cycle t is visible on err_sticky, err_any, err_cnt and first_err_* after edge t.
- Pointer wrap: when exp pointers are at 2*DEPTH−1, they roll to 0. This is not an error.
- Simultaneous write and read at occ==DEPTH with full=1: the write is refused and flagged OVF, and the read is accepted. Net occ becomes DEPTH−1. The symmetric rule applies at empty.
- Reset mid-operation clears all state immediately, with no dependency on clk.
- Shadow state is never resynchronised to DUT pointers. After a PTR error, mismatches persist until reset.

## Structure
- Package fifo_mon_pkg holds:
  - error-bit indices ERR_OVF=0, ERR_UDF=1, ERR_FLAG=2, ERR_PTR=3
  - NUM_ERR=4
  - typedef logic [NUM_ERR-1:0] fifo_err_t
- Sub-module fifo_mon_ch covers one channel: shadow pointers, occupancy and the detection logic. It outputs fifo_err_t and occ.
- The top generates NUM_CH instances of fifo_mon_ch and implements the sticky aggregation, the saturating counter, the first-error priority encoder and clr.

## Test plan
- Reset, then 16 clean writes on ch0 with matching wr_ptr 1..16, full rising on the 16th -> occ ch0=16 and err_any=0 throughout.
- ch1 empty=1, ren=1 for one cycle -> next cycle err_sticky[7:4]=4'b0010, err_cnt=1, first_err_ch=1, first_err_type=4'b0010.
- ch0 at occ=5 with wen=ren=1 for 3 cycles and consistent pointers -> occ stays 5, exp pointers +3 each, no error.
- 40 write/read pairs on ch0 with pointers wrapping 31->0 -> no PTR error. Then force wr_ptr off by one -> bit3 set next cycle.
- ch0 occ=3 while DUT drives empty=1 -> bit2 set. Simultaneously an OVF on ch1 -> first_err_ch=0.
- With ERR_CNT_W=8, 300 consecutive error cycles -> err_cnt=255. Pulse clr while an error is present -> err_cnt=0, err_sticky=0, first_err_valid=0 after the edge. Assert rst mid-burst -> all outputs 0 immediately.
